lenet_sample_loader: RTL and testbench
======================================

// Module: lenet_sample_loader
// PURPOSE
//  Host-side initiator for the LeNet inference core: accepts one 28x28 8-bit grayscale frame on a
//  valid/ready stream and converts each pixel to signed fixed point. Writes the frame, zero-padded,
//  into a 32x32 sample buffer that the core reads. Then drives the core's start/done handshake and
//  returns the inferred digit on a valid/ready result port.
// PARAMETERS
//  IMG_W      28  input frame width = height, in pixels
//  PAD        2   zero border on each side; buffer side = IMG_W+2*PAD = 32 (1024 words)
//  FRAC_BITS  16  fractional bits of sample words; pixel p maps to p << (FRAC_BITS-8), range [0,1)
//  DATA_W     32  sample word width (signed)
// PORTS
//  Clk               in   1   clock
//  Reset             in   1   asynchronous active-low reset
//  pix_valid         in   1   pixel stream valid
//  pix_ready         out  1   pixel stream ready
//  pix_data          in   8   unsigned grayscale pixel, raster order
//  pix_last          in   1   marks the final (784th) pixel of a frame
//  sample_data_addr  in   10  core read address into the sample buffer
//  sample_data_data  out  32  signed sample word; 1-cycle registered read latency
//  lenet_start       out  1   start to the core; level, held until done is seen
//  lenet_done        in   1   core done level
//  lenet_inference   in   4   core result, valid while lenet_done=1
//  res_valid         out  1   result valid
//  res_ready         in   1   result consumer ready
//  res_digit         out  4   latched digit 0..9
//  busy              out  1   high in every state except IDLE
//  frame_err         out  1   1-cycle pulse on a frame-length violation
// BEHAVIOUR
//  Reset: state=IDLE; pix_ready, lenet_start, res_valid, busy, frame_err = 0; res_digit = 0.
//   Buffer contents are not reset.
//  FSM: IDLE -> CLEAR -> LOAD -> RUN -> RELEASE -> RESULT -> IDLE.
//  IDLE: pix_ready=0. pix_valid=1 -> CLEAR. The pixel is not consumed.
//  CLEAR: writes 0 to addresses 0..1023, one per cycle (1024 cycles), pix_ready=0; then -> LOAD.
//  LOAD: pix_ready=1. Each handshake writes addr = (row+PAD)*32 + (col+PAD).
//   col wraps at IMG_W-1 and increments row.
//  After the 784th handshake -> RUN. If that beat has pix_last=0, pulse frame_err and still -> RUN.
//  pix_last=1 on an earlier beat: pulse frame_err, abort -> IDLE with lenet_start never raised.
//  RUN: lenet_start=1. On lenet_done=1, latch res_digit <= lenet_inference, then -> RELEASE.
//  RELEASE: lenet_start=0. Wait for lenet_done=0 (core back in IDLE), then -> RESULT.
//  RESULT: res_valid=1, res_digit stable. res_valid&res_ready -> IDLE; res_valid falls next cycle.
//  No new frame is accepted until the result is consumed (back-pressure via pix_ready=0).
//  Read port: sample_data_data <= buf[sample_data_addr] every cycle, any state.
//   Read and write to the same address in one cycle returns the old data.
//  Arithmetic: word = {{(DATA_W-FRAC_BITS){1'b0}}, pix, {(FRAC_BITS-8){1'b0}}}; never negative.
//  Reset mid-frame or mid-run: FSM -> IDLE and lenet_start drops asynchronously.
//   The core sees ~start and returns to its IDLE.
// CONFIGURATION
//  SAMPLE_INVERT_EN defined: the stored pixel is 255-pix_data (white-on-black camera frames).
//   This applies to interior pixels only; border words stay 0.
//  Not defined: pix_data is stored as received.
// STRUCTURE
//  Package lenet_pkg holds: IMG_W, PAD, BUF_SIDE=32, BUF_WORDS=1024, FRAC_BITS,
//   the loader_state_t enum, and the typedef sample_t = logic signed [31:0].
//  Sub-module sample_ram: 1024x32 simple dual-port RAM, one write port, one registered read port.
// TESTING
//  1. Frame of 784 pixels all 0xFF, LeNet model returns done with 4'd7 -> start high after load;
//     addr 66 (row2,col2) reads 0x0000FF00; addr 0 and 1023 read 0;
//     res_valid with res_digit=7.
//  2. pix_last asserted on pixel 100 -> frame_err pulse; lenet_start stays 0; busy falls;
//     next full frame loads normally.
//  3. 784th pixel without pix_last -> frame_err pulse; start still raised; pix_ready=0 afterwards.
//  4. res_ready held 0 for 50 cycles with pix_valid=1 -> res_valid and res_digit stable,
//     pix_ready=0 throughout.
//  5. Reset asserted during LOAD at pixel 400 -> all outputs 0 immediately;
//     a new frame afterwards has no stale interior pixels (CLEAR verified).
//  6. With SAMPLE_INVERT_EN defined, pixel 0x00 at (0,0) -> addr 66 reads 0x0000FF00;
//     border addr 0 reads 0.

Source files
------------

// File: rtl/lenet_pkg.sv
// Shared constants, state encoding and sample word type for the LeNet sample loader.
package lenet_pkg;
   localparam int IMG_W     = 28;
   localparam int PAD       = 2;
   localparam int BUF_SIDE  = IMG_W + 2*PAD;
   localparam int BUF_WORDS = BUF_SIDE*BUF_SIDE;
   localparam int FRAC_BITS = 16;
   localparam int DATA_W    = 32;
   localparam int ADDR_W    = $clog2(BUF_WORDS);
   localparam int POS_W     = $clog2(BUF_SIDE);

   typedef logic signed [DATA_W-1:0] sample_t;

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_RELEASE, S_RESULT
   } loader_state_t;

   // 8-bit pixel to fixed point in [0,1); upper bits are zero so the word is never negative
   function automatic sample_t pix_to_sample(input logic [7:0] pix);
      return sample_t'({{(DATA_W-FRAC_BITS){1'b0}}, pix, {(FRAC_BITS-8){1'b0}}});
   endfunction
endpackage

// File: rtl/lenet_sample_loader_sample_ram.sv
// 1024x32 simple dual-port sample buffer: one write port, one registered read port.
// A same-address read and write in one cycle returns the old word.
module sample_ram import lenet_pkg::*; (
   input  logic              Clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  sample_t           wdata,
   input  logic [ADDR_W-1:0] raddr,
   output sample_t           rdata
);
   sample_t mem [BUF_WORDS];

   always_ff @(posedge Clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/lenet_sample_loader.sv
// Loads one 28x28 frame, zero-padded, into the 32x32 sample buffer, runs the LeNet core and
// returns its digit. Build option SAMPLE_INVERT_EN stores 255-pix for interior pixels.
module lenet_sample_loader import lenet_pkg::*; (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [7:0]        pix_data,
   input  logic              pix_last,
   input  logic [ADDR_W-1:0] sample_data_addr,
   output sample_t           sample_data_data,
   output logic              lenet_start,
   input  logic              lenet_done,
   input  logic [3:0]        lenet_inference,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [3:0]        res_digit,
   output logic              busy,
   output logic              frame_err
);
   loader_state_t     state, state_nxt;
   logic [ADDR_W-1:0] clr_addr;
   logic [POS_W-1:0]  row, col;
   logic              pix_hs, last_pos, we;
   logic [ADDR_W-1:0] waddr;
   sample_t           wdata;
   logic [7:0]        pix_val;

   assign pix_hs   = (state == S_LOAD) && pix_valid;
   assign last_pos = (row == POS_W'(IMG_W-1)) && (col == POS_W'(IMG_W-1));

`ifdef SAMPLE_INVERT_EN
   assign pix_val = 8'hFF - pix_data;
`else
   assign pix_val = pix_data;
`endif

   // start is a pure state decode so an async reset drops it immediately
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      pix_ready   = 1'b0;
      lenet_start = 1'b0;
      res_valid   = 1'b0;
      busy        = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (pix_valid) state_nxt = S_CLEAR;
         end
         S_CLEAR:
            if (clr_addr == ADDR_W'(BUF_WORDS-1)) state_nxt = S_LOAD;
         S_LOAD: begin
            pix_ready = 1'b1;
            if (pix_valid) begin
               if (last_pos)      state_nxt = S_RUN;
               else if (pix_last) state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            lenet_start = 1'b1;
            if (lenet_done) state_nxt = S_RELEASE;
         end
         S_RELEASE:
            if (!lenet_done) state_nxt = S_RESULT;
         S_RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         clr_addr  <= '0;
         row       <= '0;
         col       <= '0;
         frame_err <= 1'b0;
         res_digit <= '0;
      end else begin
         // error when pix_last disagrees with the 784th position, either early or missing
         frame_err <= pix_hs && (last_pos ^ pix_last);
         if (state == S_CLEAR) clr_addr <= clr_addr + 1'b1;
         else                  clr_addr <= '0;
         if (state != S_LOAD) begin
            row <= '0;
            col <= '0;
         end else if (pix_valid) begin
            if (col == POS_W'(IMG_W-1)) begin
               col <= '0;
               row <= row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (state == S_RUN && lenet_done) res_digit <= lenet_inference;
      end
   end

   assign we    = (state == S_CLEAR) || pix_hs;
   assign waddr = (state == S_CLEAR) ? clr_addr : {row + POS_W'(PAD), col + POS_W'(PAD)};
   assign wdata = (state == S_CLEAR) ? '0 : pix_to_sample(pix_val);

   sample_ram u_ram (
      .Clk   (Clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (sample_data_addr),
      .rdata (sample_data_data)
   );
endmodule

// File: tb/tb_lenet_sample_loader.sv
// Scoreboard bench for lenet_sample_loader: random frames, a LeNet core model that reads back
// the whole sample buffer, and a monitor that checks frame_err pulses and result handshakes.
module tb_lenet_sample_loader;
   import lenet_pkg::*;

   logic              Clk = 1'b0;
   logic              Reset = 1'b0;
   logic              pix_valid = 1'b0, pix_last = 1'b0;
   logic [7:0]        pix_data = '0;
   logic              pix_ready;
   logic [ADDR_W-1:0] sample_data_addr = '0;
   sample_t           sample_data_data;
   logic              lenet_start;
   logic              lenet_done = 1'b0;
   logic [3:0]        lenet_inference = '0;
   logic              res_valid;
   logic              res_ready = 1'b0;
   logic [3:0]        res_digit;
   logic              busy, frame_err;

   always #5 Clk = ~Clk;

   lenet_sample_loader dut (
      .Clk(Clk), .Reset(Reset),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last),
      .sample_data_addr(sample_data_addr), .sample_data_data(sample_data_data),
      .lenet_start(lenet_start), .lenet_done(lenet_done), .lenet_inference(lenet_inference),
      .res_valid(res_valid), .res_ready(res_ready), .res_digit(res_digit),
      .busy(busy), .frame_err(frame_err)
   );

   typedef struct { bit is_err; logic [3:0] digit; } ev_t;
   ev_t         sb[$];
   int          n_cmp = 0, n_bad = 0;
   logic [7:0]  frame_pix [784];
   logic [31:0] exp_img [1024];
   logic [3:0]  core_digit = '0;
   int          started_cnt = 0;
   bit          hold = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference image: zero everywhere except the 28x28 interior, pixel scaled by 2^8
   function automatic void build_exp();
      int r, c, p;
      for (int a = 0; a < 1024; a++) begin
         r = a / 32;
         c = a % 32;
         if (r >= 2 && r < 30 && c >= 2 && c < 30) begin
            p = int'(frame_pix[(r-2)*28 + (c-2)]);
`ifdef SAMPLE_INVERT_EN
            p = 255 - p;
`endif
            exp_img[a] = 32'(p * 256);
         end else begin
            exp_img[a] = 32'd0;
         end
      end
   endfunction

   function automatic void rand_frame();
      for (int i = 0; i < 784; i++) frame_pix[i] = 8'($urandom_range(0, 255));
   endfunction

   task automatic push_ev(input bit is_err, input logic [3:0] dig);
      ev_t e;
      e.is_err = is_err;
      e.digit  = dig;
      sb.push_back(e);
   endtask

   task automatic send_frame(input int n, input int last_at, input bit gaps);
      bit hs;
      int t;
      for (int i = 0; i < n; i++) begin
         if (gaps)
            while ($urandom_range(0, 3) == 0) begin
               pix_valid = 1'b0;
               @(posedge Clk); #1;
            end
         pix_valid = 1'b1;
         pix_data  = frame_pix[i];
         pix_last  = (i == last_at);
         hs = 1'b0;
         t  = 0;
         while (!hs && t < 3000) begin
            @(negedge Clk);
            hs = pix_ready;
            @(posedge Clk); #1;
            t++;
         end
         if (!hs) begin
            n_cmp++; n_bad++;
            $display("FAIL pix_handshake_timeout: pixel %0d not accepted, required within 3000 cycles", i);
            break;
         end
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic post_load();
      @(negedge Clk);
      chk("pix_ready_after_load", 32'(pix_ready), 32'd0);
      chk("start_after_load", 32'(lenet_start), 32'd1);
      chk("busy_after_load", 32'(busy), 32'd1);
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 6000) begin
         @(negedge Clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d events outstanding, expected 0", sb.size());
      end
   endtask

   task automatic run_full(input logic [3:0] dig, input bit no_last, input bit gaps);
      core_digit = dig;
      build_exp();
      if (no_last) push_ev(1'b1, 4'd0);
      push_ev(1'b0, dig);
      send_frame(784, no_last ? -1 : 783, gaps);
      post_load();
      wait_drain();
   endtask

   // Consumer-side ready, random unless the bench is holding it low
   initial begin : res_ready_drv
      forever begin
         @(posedge Clk); #1;
         res_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      end
   end

   // LeNet core model: on start, read back and verify every buffer word, then answer done
   initial begin : core_model
      int t, drops;
      forever begin
         @(negedge Clk);
         if (Reset && lenet_start && !lenet_done) begin
            started_cnt++;
            drops = 0;
            for (int a = 0; a < 1024; a++) begin
               sample_data_addr = ADDR_W'(a);
               @(posedge Clk); #1;
               chk($sformatf("sample_word[%0d]", a), sample_data_data, exp_img[a]);
               if (!lenet_start) drops++;
            end
            chk("start_held_while_running", 32'(drops), 32'd0);
            lenet_inference = core_digit;
            lenet_done = 1'b1;
            t = 0;
            while (lenet_start && t < 100) begin
               @(negedge Clk);
               t++;
            end
            chk("start_released_after_done", 32'(lenet_start), 32'd0);
            @(posedge Clk); #1;
            lenet_done = 1'b0;
            lenet_inference = 4'($urandom_range(10, 15));
         end
      end
   end

   // Monitor: frame_err pulses and result handshakes against the scoreboard queue
   initial begin : monitor
      ev_t e;
      forever begin
         @(negedge Clk);
         if (Reset && (frame_err || (res_valid && res_ready))) begin
            if (sb.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_event: frame_err=%0b result=%0b, expected none",
                        frame_err, res_valid && res_ready);
            end else begin
               e = sb.pop_front();
               chk("event_is_frame_err", 32'(frame_err), 32'(e.is_err));
               if (!e.is_err) chk("res_digit", 32'(res_digit), 32'(e.digit));
            end
         end
      end
   end

   initial begin : watchdog
      #700000;
      $display("FAIL watchdog: simulation exceeded 70000 cycles");
      $fatal(1);
   end

   initial begin : stim
      int cnt, t;
      repeat (3) @(negedge Clk);
      chk("rst_pix_ready", 32'(pix_ready), 32'd0);
      chk("rst_lenet_start", 32'(lenet_start), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_res_digit", 32'(res_digit), 32'd0);
      Reset = 1'b1;
      @(posedge Clk); #1;

      // all-white frame, core answers 7
      for (int i = 0; i < 784; i++) frame_pix[i] = 8'hFF;
      run_full(4'd7, 1'b0, 1'b0);

      // early pix_last on pixel 100: abort without ever starting the core
      rand_frame();
      cnt = started_cnt;
      push_ev(1'b1, 4'd0);
      send_frame(100, 99, 1'b1);
      repeat (4) @(negedge Clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_pix_ready", 32'(pix_ready), 32'd0);
      chk("abort_start", 32'(lenet_start), 32'd0);
      wait_drain();
      chk("abort_no_core_start", 32'(started_cnt), 32'(cnt));

      rand_frame();
      run_full(4'($urandom_range(0, 9)), 1'b0, 1'b1);

      // 784th pixel without pix_last: error pulse but the run proceeds
      rand_frame();
      run_full(4'($urandom_range(0, 9)), 1'b1, 1'b0);

      // result back-pressure with a new frame waiting
      hold = 1'b1;
      rand_frame();
      core_digit = 4'($urandom_range(0, 9));
      build_exp();
      push_ev(1'b0, core_digit);
      send_frame(784, 783, 1'b1);
      post_load();
      t = 0;
      while (!res_valid && t < 4000) begin
         @(negedge Clk);
         t++;
      end
      chk("bp_result_arrives", 32'(res_valid), 32'd1);
      @(posedge Clk); #1;
      pix_valid = 1'b1;
      pix_data  = 8'h5A;
      repeat (50) begin
         @(negedge Clk);
         chk("bp_res_valid", 32'(res_valid), 32'd1);
         chk("bp_res_digit", 32'(res_digit), 32'(core_digit));
         chk("bp_pix_ready", 32'(pix_ready), 32'd0);
      end
      @(posedge Clk); #1;
      pix_valid = 1'b0;
      hold = 1'b0;
      wait_drain();

      // async reset in the middle of a load
      rand_frame();
      cnt = started_cnt;
      send_frame(400, -1, 1'b1);
      #2 Reset = 1'b0;
      #1;
      chk("mid_rst_outputs", 32'({pix_ready, busy, lenet_start, res_valid, frame_err, res_digit}), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      chk("mid_rst_no_core_start", 32'(started_cnt), 32'(cnt));
      rand_frame();
      run_full(4'($urandom_range(0, 9)), 1'b0, 1'b0);

      // black pixel at (0,0) lands at address 66
      rand_frame();
      frame_pix[0] = 8'h00;
      run_full(4'($urandom_range(0, 9)), 1'b0, 1'b1);

      for (int k = 0; k < 2; k++) begin
         rand_frame();
         run_full(4'($urandom_range(0, 9)), 1'b0, 1'b1);
      end

      repeat (5) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
